mca_input_sequencer: RTL and testbench

- Producer side of the FIR adder-tree interface: feeds the hierarchical multi-cycle adder and collects its result.
- Shifts N-bit CBADC control vectors into a K-deep window.
- Every DOWN_SAMPLE_RATE accepted vectors, freezes a stable S_matrix snapshot and pulses start to the adder tree.
- Counts the fixed adder latency, captures the returned sample and presents it with a one-cycle out_valid strobe.

---
 rtl/mca_input_sequencer_pkg.sv | 31 +++
 rtl/mca_input_sequencer_if.sv | 67 ++++++
 rtl/mca_input_sequencer_control_window_shift_reg.sv | 62 ++++++
 rtl/mca_input_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mca_input_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mca_input_sequencer_pkg.sv
// Shared definitions for the MCA input sequencer slice.
//
// Purpose: default sizing constants, the sequencer FSM state type, the
// control-vector type and a small counter-width helper used by the
// interface, the window sub-module and the top.
//
// Ports: none (package).

package mca_input_sequencer_pkg;

    localparam int K_DEFAULT                 = 256;
    localparam int N_DEFAULT                 = 8;
    localparam int WIDTH_COEFFICIENT_DEFAULT = 32;
    localparam int DOWN_SAMPLE_RATE_DEFAULT  = 16;
    localparam int ADDER_LATENCY_DEFAULT     = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    typedef logic [N_DEFAULT-1:0] ctrl_vec_t;

    // Width needed to hold the values 0..n-1, never narrower than one bit
    // so that degenerate counters (n == 1) still have a legal vector.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mca_input_sequencer_if.sv
// Bus interface between the MCA input sequencer and its surroundings.
//
// Purpose: groups the CBADC input handshake, the adder-tree snapshot/start
// and result signals, and the status outputs.
//
// Signals:
//   in_valid, in_data       control vector stream from the CBADC
//   S_matrix, start         frozen window and start pulse to the adder tree
//   adder_sample            result returned by the adder tree
//   out_valid, out_sample   captured FIR output and its one-cycle strobe
//   busy, overrun           frame in flight / sticky frame-dropped flag
//   drop_count              only when MCA_SEQ_DROP_COUNT_EN is defined
//
// Modports: master = sequencer side, slave = environment side.

interface mca_input_sequencer_if
    import mca_input_sequencer_pkg::*;
#(
    parameter int K                 = K_DEFAULT,
    parameter int N                 = N_DEFAULT,
    parameter int WIDTH_COEFFICIENT = WIDTH_COEFFICIENT_DEFAULT
) ();

    logic                                in_valid;
    logic [N-1:0]                        in_data;
    logic [K-1:0][N-1:0]                 S_matrix;
    logic                                start;
    logic signed [WIDTH_COEFFICIENT-1:0] adder_sample;
    logic                                out_valid;
    logic signed [WIDTH_COEFFICIENT-1:0] out_sample;
    logic                                busy;
    logic                                overrun;
`ifdef MCA_SEQ_DROP_COUNT_EN
    logic [15:0]                         drop_count;
`endif

    modport master (
        input  in_valid,
        input  in_data,
        input  adder_sample,
        output S_matrix,
        output start,
        output out_valid,
        output out_sample,
        output busy,
`ifdef MCA_SEQ_DROP_COUNT_EN
        output drop_count,
`endif
        output overrun
    );

    modport slave (
        output in_valid,
        output in_data,
        output adder_sample,
        input  S_matrix,
        input  start,
        input  out_valid,
        input  out_sample,
        input  busy,
`ifdef MCA_SEQ_DROP_COUNT_EN
        input  drop_count,
`endif
        input  overrun
    );

endinterface

// File: rtl/mca_input_sequencer_control_window_shift_reg.sv
// K-deep shift window of N-bit control vectors.
//
// Purpose: holds the most recent K accepted vectors, newest at [K-1] and
// oldest at [0], and tracks how many vectors have been accepted (saturating
// at K) so the sequencer knows when the window is full.
//
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   shift_en       accept shift_in this cycle
//   shift_in       incoming control vector
//   window_next    window contents after this cycle's shift (combinational)
//   fill_count     accepted vectors so far, saturating at K
//   full           fill_count == K

module control_window_shift_reg
    import mca_input_sequencer_pkg::*;
#(
    parameter int K = K_DEFAULT,
    parameter int N = N_DEFAULT,
    localparam int FILL_W = count_width(K + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic [N-1:0]        shift_in,
    output logic [K-1:0][N-1:0] window_next,
    output logic [FILL_W-1:0]   fill_count,
    output logic                full
);

    logic [K-1:0][N-1:0] window;

    // The post-shift view is exposed so the top can snapshot the window on
    // the same edge that the triggering vector enters it.
    always_comb begin
        window_next = window;
        if (shift_en) begin
            window_next = {shift_in, window[K-1:1]};
        end
    end

    // Window storage: only moves on accepted vectors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window <= '0;
        end else begin
            window <= window_next;
        end
    end

    // Fill counter: saturates at K so the full flag stays asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_count <= '0;
        end else if (shift_en && !full) begin
            fill_count <= fill_count + FILL_W'(1);
        end
    end

    assign full = (fill_count == FILL_W'(K));

endmodule

// File: rtl/mca_input_sequencer.sv
// MCA input sequencer: producer side of the FIR adder-tree interface.
//
// Purpose: shifts CBADC control vectors into a K-deep window; every
// DOWN_SAMPLE_RATE accepted vectors (once the window is full) it freezes a
// snapshot into S_matrix and pulses start, waits ADDER_LATENCY cycles after
// the start-high cycle, captures adder_sample and strobes out_valid.
// Frames arriving while a previous one is still in flight are dropped and
// flagged on the sticky overrun output.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   bus          mca_input_sequencer_if.master (see interface header)
//
// Optional: define MCA_SEQ_DROP_COUNT_EN to add the saturating 16-bit
// drop_count output on the interface.

module mca_input_sequencer
    import mca_input_sequencer_pkg::*;
#(
    parameter int K                 = K_DEFAULT,
    parameter int N                 = N_DEFAULT,
    parameter int WIDTH_COEFFICIENT = WIDTH_COEFFICIENT_DEFAULT,
    parameter int DOWN_SAMPLE_RATE  = DOWN_SAMPLE_RATE_DEFAULT,
    parameter int ADDER_LATENCY     = ADDER_LATENCY_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    mca_input_sequencer_if.master bus
);

    localparam int FILL_W = count_width(K + 1);
    localparam int DEC_W  = count_width(DOWN_SAMPLE_RATE);
    localparam int LAT_W  = count_width(ADDER_LATENCY + 1);

    seq_state_t          state;
    seq_state_t          next_state;
    logic [K-1:0][N-1:0] window_next;
    logic [FILL_W-1:0]   fill_count;
    logic                full;
    logic [DEC_W-1:0]    dec_count;
    logic [LAT_W-1:0]    lat_count;
    logic                last_fill;
    logic                dec_hit;
    logic                frame;
    logic                capture;
    logic                frame_go;
    logic                drop;

    control_window_shift_reg #(
        .K (K),
        .N (N)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .shift_en    (bus.in_valid),
        .shift_in    (bus.in_data),
        .window_next (window_next),
        .fill_count  (fill_count),
        .full        (full)
    );

    // Frame decision for this cycle. The K-th vector always opens the first
    // frame; after that the decimation counter decides. The capture cycle
    // counts as free, so back-to-back frames can chain without a gap.
    always_comb begin
        last_fill = (fill_count == FILL_W'(K - 1));
        dec_hit   = (dec_count == DEC_W'(DOWN_SAMPLE_RATE - 1));
        frame     = bus.in_valid && (full ? dec_hit : last_fill);
        capture   = (state == RUN) && (lat_count == '0);
        frame_go  = frame && ((state != RUN) || capture);
        drop      = frame && (state == RUN) && !capture;
    end

    // Next-state logic for the FILL / IDLE / RUN sequencer.
    always_comb begin
        next_state = state;
        unique case (state)
            FILL: begin
                if (frame_go) begin
                    next_state = RUN;
                end else if (full) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (frame_go) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (capture) begin
                    next_state = frame_go ? RUN : IDLE;
                end
            end
            default: next_state = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Decimation counter: runs only on a full window and wraps on every
    // frame, including frames that end up dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_count <= '0;
        end else if (bus.in_valid && full) begin
            dec_count <= dec_hit ? '0 : dec_count + DEC_W'(1);
        end
    end

    // Latency counter: loaded when a frame starts so it reads ADDER_LATENCY
    // in the start-high cycle and reaches zero in the capture cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_count <= '0;
        end else if (frame_go) begin
            lat_count <= LAT_W'(ADDER_LATENCY);
        end else if ((state == RUN) && (lat_count != '0)) begin
            lat_count <= lat_count - LAT_W'(1);
        end
    end

    // Snapshot, start pulse, result capture and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.S_matrix   <= '0;
            bus.start      <= 1'b0;
            bus.out_sample <= '0;
            bus.out_valid  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.start     <= frame_go;
            bus.out_valid <= capture;
            if (frame_go) begin
                bus.S_matrix <= window_next;
            end
            if (capture) begin
                bus.out_sample <= bus.adder_sample;
            end
            if (drop) begin
                bus.overrun <= 1'b1;
            end
        end
    end

    assign bus.busy = (state == RUN);

`ifdef MCA_SEQ_DROP_COUNT_EN
    // Saturating count of dropped frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.drop_count <= '0;
        end else if (drop && (bus.drop_count != 16'hFFFF)) begin
            bus.drop_count <= bus.drop_count + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_mca_input_sequencer.sv
// Directed self-checking bench for mca_input_sequencer.
//
// Two instances share one stimulus stream: dut_a (DOWN_SAMPLE_RATE = 2) and
// dut_b (DOWN_SAMPLE_RATE = 1), both with K = 4, N = 3, ADDER_LATENCY = 5.
// Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_mca_input_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_data;
    logic signed [31:0] adder_sample;

    int compared   = 0;
    int mismatched = 0;

    mca_input_sequencer_if #(.K(4), .N(3), .WIDTH_COEFFICIENT(32)) bus_a ();
    mca_input_sequencer_if #(.K(4), .N(3), .WIDTH_COEFFICIENT(32)) bus_b ();

    assign bus_a.in_valid     = in_valid;
    assign bus_a.in_data      = in_data;
    assign bus_a.adder_sample = adder_sample;
    assign bus_b.in_valid     = in_valid;
    assign bus_b.in_data      = in_data;
    assign bus_b.adder_sample = adder_sample;

    mca_input_sequencer #(
        .K(4), .N(3), .WIDTH_COEFFICIENT(32),
        .DOWN_SAMPLE_RATE(2), .ADDER_LATENCY(5)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    mca_input_sequencer #(
        .K(4), .N(3), .WIDTH_COEFFICIENT(32),
        .DOWN_SAMPLE_RATE(1), .ADDER_LATENCY(5)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Drive one cycle of input, then move to 1 ns past the next edge.
    task automatic applyStimulus(input logic v, input logic [2:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // One comparison; values are widened to 64 bits (sign-extended for the
    // signed sample path).
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 3'd0;
        adder_sample = 32'sd0;
        #1;
        checkOutput("rst_start_a", 64'(bus_a.start), 64'd0);
        checkOutput("rst_busy_a", 64'(bus_a.busy), 64'd0);
        checkOutput("rst_smat_a", 64'(bus_a.S_matrix), 64'd0);
        checkOutput("rst_outv_a", 64'(bus_a.out_valid), 64'd0);
        checkOutput("rst_outs_a", 64'(bus_a.out_sample), 64'd0);
        checkOutput("rst_ovr_a", 64'(bus_a.overrun), 64'd0);
        checkOutput("rst_start_b", 64'(bus_b.start), 64'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill with vectors 1..3: nothing happens yet.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 3'(i));
            checkOutput("fill_start_a", 64'(bus_a.start), 64'd0);
            checkOutput("fill_busy_a", 64'(bus_a.busy), 64'd0);
        end
        // Vector 4 completes the window and opens the first frame.
        applyStimulus(1'b1, 3'd4);
        checkOutput("first_start_a", 64'(bus_a.start), 64'd1);
        checkOutput("first_busy_a", 64'(bus_a.busy), 64'd1);
        checkOutput("first_smat_a", 64'(bus_a.S_matrix), 64'({3'd4, 3'd3, 3'd2, 3'd1}));
        adder_sample = -32'sd1234;

        // Start-high cycle + 1 .. + 5: no output yet, still busy.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 3'd0);
            checkOutput("lat_start_a", 64'(bus_a.start), 64'd0);
            checkOutput("lat_outv_a", 64'(bus_a.out_valid), 64'd0);
            checkOutput("lat_busy_a", 64'(bus_a.busy), 64'd1);
        end
        // Start-high cycle + 6: result strobe.
        applyStimulus(1'b0, 3'd0);
        checkOutput("cap_outv_a", 64'(bus_a.out_valid), 64'd1);
        checkOutput("cap_outs_a", 64'(bus_a.out_sample), 64'(-64'sd1234));
        checkOutput("cap_busy_a", 64'(bus_a.busy), 64'd0);
        adder_sample = 32'sd77;
        applyStimulus(1'b0, 3'd0);
        checkOutput("post_outv_a", 64'(bus_a.out_valid), 64'd0);
        checkOutput("hold_outs_a", 64'(bus_a.out_sample), 64'(-64'sd1234));

        // Decimation with a 3-cycle gap between vectors 5 and 6.
        applyStimulus(1'b1, 3'd5);
        checkOutput("gap_v5_start_a", 64'(bus_a.start), 64'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0);
            checkOutput("gap_idle_start_a", 64'(bus_a.start), 64'd0);
        end
        applyStimulus(1'b1, 3'd6);
        checkOutput("gap_v6_start_a", 64'(bus_a.start), 64'd1);
        checkOutput("gap_smat_a", 64'(bus_a.S_matrix), 64'({3'd6, 3'd5, 3'd4, 3'd3}));
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, 3'd0);
            checkOutput("gap_lat_outv_a", 64'(bus_a.out_valid), 64'd0);
        end
        applyStimulus(1'b0, 3'd0);
        checkOutput("gap_cap_outv_a", 64'(bus_a.out_valid), 64'd1);
        checkOutput("gap_cap_outs_a", 64'(bus_a.out_sample), 64'd77);
        adder_sample = 32'sd555;

        // in_valid low: everything stays put.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 3'd0);
            checkOutput("quiet_start_a", 64'(bus_a.start), 64'd0);
            checkOutput("quiet_outv_a", 64'(bus_a.out_valid), 64'd0);
            checkOutput("quiet_smat_a", 64'(bus_a.S_matrix), 64'({3'd6, 3'd5, 3'd4, 3'd3}));
            checkOutput("quiet_outs_a", 64'(bus_a.out_sample), 64'd77);
        end

        // Open another frame, then reset two cycles after its start.
        applyStimulus(1'b1, 3'd7);
        checkOutput("mid_v7_start_a", 64'(bus_a.start), 64'd0);
        applyStimulus(1'b1, 3'd0);
        checkOutput("mid_v8_start_a", 64'(bus_a.start), 64'd1);
        checkOutput("mid_smat_a", 64'(bus_a.S_matrix), 64'({3'd0, 3'd7, 3'd6, 3'd5}));
        applyStimulus(1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        checkOutput("mid_busy_before_a", 64'(bus_a.busy), 64'd1);
        checkOutput("mid_ovr_before_b", 64'(bus_b.overrun), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_start_a", 64'(bus_a.start), 64'd0);
        checkOutput("mid_rst_busy_a", 64'(bus_a.busy), 64'd0);
        checkOutput("mid_rst_smat_a", 64'(bus_a.S_matrix), 64'd0);
        checkOutput("mid_rst_outs_a", 64'(bus_a.out_sample), 64'd0);
        checkOutput("mid_rst_outv_a", 64'(bus_a.out_valid), 64'd0);
        checkOutput("mid_rst_ovr_b", 64'(bus_b.overrun), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Vectors 1..10 back to back after reset. dut_a restarts on the 4th
        // vector; dut_b (every vector is a frame) drops vectors 5..9 and
        // accepts vector 10, which lands in its capture cycle. dut_a drops
        // vectors 6 and 8 and also accepts vector 10.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 3'(k));
            checkOutput("run_start_a", 64'(bus_a.start), 64'((k == 4) || (k == 10)));
            checkOutput("run_ovr_a", 64'(bus_a.overrun), 64'(k >= 6));
            checkOutput("run_start_b", 64'(bus_b.start), 64'((k == 4) || (k == 10)));
            checkOutput("run_ovr_b", 64'(bus_b.overrun), 64'(k >= 5));
            checkOutput("run_busy_b", 64'(bus_b.busy), 64'(k >= 4));
        end
        checkOutput("run_smat_b", 64'(bus_b.S_matrix), 64'({3'd2, 3'd1, 3'd0, 3'd7}));
        checkOutput("run_smat_a", 64'(bus_a.S_matrix), 64'({3'd2, 3'd1, 3'd0, 3'd7}));
`ifdef MCA_SEQ_DROP_COUNT_EN
        checkOutput("drop_count_b", 64'(bus_b.drop_count), 64'd5);
        checkOutput("drop_count_a", 64'(bus_a.drop_count), 64'd2);
`endif
        applyStimulus(1'b0, 3'd0);
        checkOutput("tail_start_b", 64'(bus_b.start), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
